mem_responder: RTL and testbench

Memory-side responder for the core's address/data bus. Accepts a request (address from the PC/ALU address mux, write data, byte enables) and executes it against an internal word-addressed RAM after a configurable number of wait states. Returns read data with a one-cycle `valid` pulse. Flags misaligned or out-of-range accesses with `err`. Sits between the core's memory address selector and the instruction/data storage, and is the wait-state model the control FSM is written against.

---
 rtl/mem_responder_pkg.sv | 32 +++
 rtl/mem_resp_array.sv | 46 ++++
 rtl/mem_responder.sv | 106 ++++++++++
 tb/tb_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus width, RAM depth, FSM state encoding,
// latched request record and the address legality check.
package mem_responder_pkg;

  localparam int unsigned REG_LEN       = 32;
  localparam int unsigned MEM_WORDS_DEF = 1024;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MEM_RESP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = MEM_IDLE,
    StWait = MEM_WAIT,
    StResp = MEM_RESP
  } mem_state_e;

  typedef struct packed {
    logic               we;
    logic [3:0]         be;
    logic [REG_LEN-1:0] addr;
    logic [REG_LEN-1:0] wdata;
  } mem_req_t;

  // Misaligned or beyond the last word; no wrap-around is ever applied.
  function automatic logic addr_err(input logic [REG_LEN-1:0] addr, input int unsigned words);
    logic [REG_LEN-1:0] word_idx;
    word_idx = {2'b00, addr[REG_LEN-1:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= REG_LEN'(words));
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only moves on an enabled read or an explicit clear.
module mem_resp_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned Words = MEM_WORDS_DEF,
  parameter int unsigned IdxW  = $clog2(Words)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [IdxW-1:0]    idx_i,
  input  logic [REG_LEN-1:0] wdata_i,
  input  logic               rd_clr_i,
  output logic [REG_LEN-1:0] rdata_o
);

  logic [REG_LEN-1:0] mem_q [Words];
  logic [REG_LEN-1:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (rd_clr_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Bus-side memory responder: latches one request, waits WAIT_CYCLES, performs the access
// and returns a one-cycle valid pulse with error flag and read data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = MEM_WORDS_DEF,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [REG_LEN-1:0] addr_i,
  input  logic [REG_LEN-1:0] wdata_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic               err_o,
  output logic [REG_LEN-1:0] rdata_o
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  mem_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  mem_req_t   req_q, req_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       acc_err;
  logic       ram_en, ram_clr;

  assign acc_err = addr_err(req_q.addr, MEM_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    valid_d = 1'b0;
    err_d   = err_q;
    ram_en  = 1'b0;
    ram_clr = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          req_d   = '{we: we_i, be: be_i, addr: addr_i, wdata: wdata_i};
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        // The RAM access lands on the same edge that raises valid.
        valid_d = 1'b1;
        err_d   = acc_err;
        ram_en  = !acc_err;
        ram_clr = acc_err && !req_q.we;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Reset must also block a write that would otherwise commit on this edge.
  mem_resp_array #(
    .Words(MEM_WORDS),
    .IdxW (IdxW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (ram_en && !rst_i),
    .we_i    (req_q.we),
    .be_i    (req_q.be),
    .idx_i   (req_q.addr[IdxW+1:2]),
    .wdata_i (req_q.wdata),
    .rd_clr_i(ram_clr),
    .rdata_o (rdata_o)
  );

  assign ready_o = (state_q == StIdle) && !rst_i;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table on the 2-wait-state instance plus
// hand sequences for back-to-back requests, mid-transaction reset and zero wait states.
module tb_mem_responder;
  import mem_responder_pkg::*;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a   [2];
  logic        we_a    [2];
  logic [3:0]  be_a    [2];
  logic [31:0] addr_a  [2];
  logic [31:0] wdata_a [2];
  logic        ready_a [2];
  logic        valid_a [2];
  logic        err_a   [2];
  logic [31:0] rdata_a [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_a[0]), .we_i(we_a[0]), .be_i(be_a[0]),
    .addr_i(addr_a[0]), .wdata_i(wdata_a[0]), .ready_o(ready_a[0]), .valid_o(valid_a[0]),
    .err_o(err_a[0]), .rdata_o(rdata_a[0])
  );

  mem_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req_a[1]), .we_i(we_a[1]), .be_i(be_a[1]),
    .addr_i(addr_a[1]), .wdata_i(wdata_a[1]), .ready_o(ready_a[1]), .valid_o(valid_a[1]),
    .err_o(err_a[1]), .rdata_o(rdata_a[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on instance d; returns edges from acceptance to valid (99 if none).
  task automatic txn(input int d, input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, output int lat, output logic err,
                     output logic [31:0] rdata);
    int n;
    n = 0;
    while (!ready_a[d] && n < 20) begin
      step();
      n++;
    end
    req_a[d] = 1'b1; we_a[d] = we; be_a[d] = be; addr_a[d] = addr; wdata_a[d] = wdata;
    step();
    req_a[d] = 1'b0;
    lat = 99; err = 1'bx; rdata = 'x;
    for (int k = 0; k < 20; k++) begin
      if (valid_a[d]) begin
        lat = k; err = err_a[d]; rdata = rdata_a[d];
        break;
      end
      step();
    end
    step();
    check("valid_pulse", 32'(valid_a[d]), 32'd0);
  endtask

  vec_t        vecs [21];
  int          lat;
  logic        e;
  logic [31:0] rd;

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0102_0304, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h0506_0708, 1'b0, 32'h0000_0000};
    vecs[2]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[3]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 4'h1, 32'h0000_0010, 32'h0000_00AA, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEAA};
    vecs[6]  = '{1'b0, 4'h0, 32'h0000_0012, 32'h0,         1'b1, 32'h0000_0000};
    vecs[7]  = '{1'b0, 4'h0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEAA};
    vecs[9]  = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEAA};
    vecs[10] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEAA};
    vecs[11] = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEAA};
    vecs[12] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 32'h0102_0304};
    vecs[13] = '{1'b1, 4'hF, 32'h0000_0014, 32'hCAFE_F00D, 1'b0, 32'h0102_0304};
    vecs[14] = '{1'b1, 4'hF, 32'h0000_0016, 32'h1111_1111, 1'b1, 32'h0102_0304};
    vecs[15] = '{1'b1, 4'h6, 32'h0000_0014, 32'hAABB_CCDD, 1'b0, 32'h0102_0304};
    vecs[16] = '{1'b0, 4'h0, 32'h0000_0014, 32'h0,         1'b0, 32'hCABB_CC0D};
    vecs[17] = '{1'b1, 4'hF, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 32'hCABB_CC0D};
    vecs[18] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h7654_3210, 1'b0, 32'hCABB_CC0D};
    vecs[19] = '{1'b0, 4'h0, 32'h0000_0FFC, 32'h0,         1'b0, 32'h7654_3210};
    vecs[20] = '{1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};

    for (int d = 0; d < 2; d++) begin
      req_a[d] = 1'b0; we_a[d] = 1'b0; be_a[d] = 4'h0; addr_a[d] = '0; wdata_a[d] = '0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(ready_a[d]), 32'd0);
      check("rst_valid", 32'(valid_a[d]), 32'd0);
      check("rst_err", 32'(err_a[d]), 32'd0);
      check("rst_rdata", rdata_a[d], 32'd0);
    end
    rst = 1'b0;
    step();
    check("ready_after_rst", 32'(ready_a[0]), 32'd1);

    // Vector table on the 2-wait-state instance
    for (int i = 0; i < 21; i++) begin
      txn(0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, lat, e, rd);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Continuous req: dropped requests, one valid per accept, spacing 4, ready low 3 cycles
    begin
      logic [31:0] expq [$];
      int          acc_c [$];
      int          nvalid, low_run;
      nvalid = 0; low_run = 0;
      for (int c = 0; c < 26; c++) begin
        if (valid_a[0]) begin
          nvalid++;
          if (expq.size() == 0) check("b2b_spurious_valid", 32'd1, 32'd0);
          else check("b2b_rdata", rdata_a[0], expq.pop_front());
        end
        req_a[0] = 1'b1; we_a[0] = 1'b0;
        addr_a[0] = ((c / 3) % 2 == 1) ? 32'h4 : 32'h0;
        if (ready_a[0]) begin
          if (low_run > 0) check("b2b_ready_low_run", 32'(low_run), 32'd3);
          low_run = 0;
          acc_c.push_back(c);
          expq.push_back(addr_a[0] == 32'h4 ? 32'h0506_0708 : 32'h0102_0304);
        end else begin
          low_run++;
        end
        step();
      end
      req_a[0] = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (valid_a[0]) begin
          nvalid++;
          if (expq.size() == 0) check("b2b_spurious_valid", 32'd1, 32'd0);
          else check("b2b_rdata", rdata_a[0], expq.pop_front());
        end
        step();
      end
      check("b2b_accepts", 32'(acc_c.size()), 32'd7);
      check("b2b_valid_count", 32'(nvalid), 32'(acc_c.size()));
      for (int k = 1; k < acc_c.size(); k++) begin
        check("b2b_spacing", 32'(acc_c[k] - acc_c[k-1]), 32'd4);
      end
    end

    // Reset during WAIT (k=1) and during RESP (k=2): no valid, write not committed
    for (int k = 1; k <= 2; k++) begin
      int nv;
      nv = 0;
      req_a[0] = 1'b1; we_a[0] = 1'b1; be_a[0] = 4'hF; addr_a[0] = 32'h20;
      wdata_a[0] = (k == 1) ? 32'h1234_5678 : 32'h55AA_55AA;
      step();
      req_a[0] = 1'b0;
      repeat (k) step();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
        step();
        if (valid_a[0]) nv++;
      end
      check("midrst_ready", 32'(ready_a[0]), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
        step();
        if (valid_a[0]) nv++;
      end
      check($sformatf("midrst%0d_no_valid", k), 32'(nv), 32'd0);
      txn(0, 1'b0, 4'h0, 32'h20, 32'h0, lat, e, rd);
      check($sformatf("midrst%0d_latency", k), 32'(lat), 32'd3);
      check($sformatf("midrst%0d_rdata", k), rd, 32'h0BAD_F00D);
    end

    // Zero wait states
    txn(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, lat, e, rd);
    check("w0_write_latency", 32'(lat), 32'd1);
    check("w0_write_err", 32'(e), 32'd0);
    req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 32'h10;
    step();
    req_a[1] = 1'b0;
    check("w0_ready_busy", 32'(ready_a[1]), 32'd0);
    check("w0_valid_early", 32'(valid_a[1]), 32'd0);
    step();
    check("w0_valid", 32'(valid_a[1]), 32'd1);
    check("w0_ready_back", 32'(ready_a[1]), 32'd1);
    check("w0_rdata", rdata_a[1], 32'hDEAD_BEEF);
    check("w0_err", 32'(err_a[1]), 32'd0);
    step();
    check("w0_valid_pulse", 32'(valid_a[1]), 32'd0);
    txn(1, 1'b0, 4'h0, 32'h11, 32'h0, lat, e, rd);
    check("w0_mis_latency", 32'(lat), 32'd1);
    check("w0_mis_err", 32'(e), 32'd1);
    check("w0_mis_rdata", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
